// File: rtl/chan_err_inj_pkg.sv
// Shared types, constants and helpers for the channel error injector.
package chan_inj_pkg;

  typedef enum logic [1:0] {
    MODE_OFF      = 2'd0,
    MODE_PERIODIC = 2'd1,
    MODE_RANDOM   = 2'd2,
    MODE_ONESHOT  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_CLEAN = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Galois taps for x^16+x^14+x^13+x^11+1 in right-shift form.
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Number of set bits in a 16-bit word.
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
    return n;
  endfunction

  // 32-bit add that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/chan_err_inj_if.sv
// Symbol stream, control and statistics bundle of the channel error injector.
interface chan_err_inj_if #(
  parameter int W         = 2,
  parameter int MAX_BURST = 8
);
  localparam int BLW = $clog2(MAX_BURST + 1);

  logic [1:0]     mode_i;
  logic [BLW-1:0] burst_len_i;
  logic [7:0]     rate_i;
  logic           inj_i;
  logic           valid_i;
  logic [W-1:0]   sym_i;
  logic           valid_o;
  logic [W-1:0]   sym_o;
  logic [W-1:0]   err_o;
  logic [31:0]    sym_ct_o;
  logic [31:0]    err_sym_ct_o;
  logic [31:0]    err_bit_ct_o;
  logic           window_done_o;

  // Driver side: encoder plus control software.
  modport master (
    output mode_i, burst_len_i, rate_i, inj_i, valid_i, sym_i,
    input  valid_o, sym_o, err_o, sym_ct_o, err_sym_ct_o, err_bit_ct_o, window_done_o
  );

  // Injector side.
  modport slave (
    input  mode_i, burst_len_i, rate_i, inj_i, valid_i, sym_i,
    output valid_o, sym_o, err_o, sym_ct_o, err_sym_ct_o, err_bit_ct_o, window_done_o
  );
endinterface

// File: rtl/chan_err_inj_lfsr16.sv
// 16-bit Galois LFSR that advances one step per enabled cycle.
module lfsr16
  import chan_inj_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] state
);
  // An all-zero seed would lock the register, so it falls back to the default.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0) ? DEFAULT_SEED : SEED;

  // Shift right, folding the taps in when a one drops out of the LSB.
  always_ff @(posedge clk) begin
    if (rst)     state <= SEED_EFF;
    else if (en) state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0);
  end
endmodule

// File: rtl/chan_err_inj.sv
// Channel error injector: one register stage that corrupts selected symbols
// in bursts and keeps error statistics over a measurement window.
module chan_err_inj
  import chan_inj_pkg::*;
#(
  parameter int          W           = 2,
  parameter int          PERIOD_LOG2 = 5,
  parameter int          MAX_BURST   = 8,
  parameter int          WINDOW      = 256,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input logic           clk,
  input logic           rst,
  chan_err_inj_if.slave bus
);
  localparam int          BLW     = $clog2(MAX_BURST + 1);
  localparam bit          WIN_EN  = (WINDOW != 0);
  localparam logic [31:0] LAST_CT = 32'(WINDOW - 1);

  state_e         state_q, state_d;
  logic [BLW-1:0] rem_q, rem_d;
  logic           pend_q;
  logic [15:0]    lfsr_q;
  logic           valid_q;
  logic [W-1:0]   sym_q, err_q;
  logic [31:0]    sym_ct_q, err_sym_ct_q, err_bit_ct_q;

  logic [BLW-1:0] blen;
  logic [W-1:0]   mask_raw, mask, err_d;
  logic           trig, hit;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (bus.valid_i),
    .state (lfsr_q)
  );

  // Effective burst length, trigger condition and the mask for this symbol.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    blen = bus.burst_len_i;
    if (blen == '0)                    blen = BLW'(1);
    else if (blen > BLW'(MAX_BURST))   blen = BLW'(MAX_BURST);

    mask_raw = W'(lfsr_q >> (16 - W));
    mask     = (mask_raw == '0) ? W'(1) : mask_raw;

    trig = 1'b0;
    case (mode_e'(bus.mode_i))
      MODE_PERIODIC: trig = &sym_ct_q[PERIOD_LOG2-1:0];
      MODE_RANDOM:   trig = (lfsr_q[7:0] < bus.rate_i);
      MODE_ONESHOT:  trig = pend_q | bus.inj_i;
      default:       trig = 1'b0;
    endcase
  end

  // Burst FSM next state; only consumed when a symbol is accepted.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    hit     = 1'b0;
    case (state_q)
      ST_CLEAN: begin
        if (trig) begin
          hit = 1'b1;
          if (blen != BLW'(1)) begin
            rem_d   = blen - BLW'(1);
            state_d = ST_BURST;
          end
        end
      end
      ST_BURST: begin
        if (mode_e'(bus.mode_i) == MODE_OFF) begin
          state_d = ST_CLEAN;
        end else begin
          hit   = 1'b1;
          rem_d = rem_q - BLW'(1);
          if (rem_q == BLW'(1)) state_d = ST_CLEAN;
        end
      end
      default: ;
    endcase
    // The window-completing symbol is still processed, then everything freezes.
    if (WIN_EN && state_q != ST_DONE && sym_ct_q == LAST_CT) state_d = ST_DONE;
    err_d = hit ? mask : '0;
  end

  // Registered outputs, FSM state, one-shot latch and statistics counters.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others.
    if (rst) begin
      state_q      <= ST_CLEAN;
      rem_q        <= '0;
      pend_q       <= 1'b0;
      valid_q      <= 1'b0;
      sym_q        <= '0;
      err_q        <= '0;
      sym_ct_q     <= '0;
      err_sym_ct_q <= '0;
      err_bit_ct_q <= '0;
    end else begin
      valid_q <= bus.valid_i;
      if (bus.valid_i) begin
        state_q <= state_d;
        rem_q   <= rem_d;
        pend_q  <= 1'b0;
        sym_q   <= bus.sym_i ^ err_d;
        err_q   <= err_d;
        if (state_q != ST_DONE) begin
          sym_ct_q     <= sat_add32(sym_ct_q, 32'd1);
          err_sym_ct_q <= sat_add32(err_sym_ct_q, 32'(|err_d));
          err_bit_ct_q <= sat_add32(err_bit_ct_q, 32'(popcount16(16'(err_d))));
        end
      end else if (bus.inj_i) begin
        pend_q <= 1'b1;
      end
    end
  end

  assign bus.valid_o       = valid_q;
  assign bus.sym_o         = sym_q;
  assign bus.err_o         = err_q;
  assign bus.sym_ct_o      = sym_ct_q;
  assign bus.err_sym_ct_o  = err_sym_ct_q;
  assign bus.err_bit_ct_o  = err_bit_ct_q;
  assign bus.window_done_o = (state_q == ST_DONE);

endmodule

// File: doc/chan_err_inj.md
# chan_err_inj

Parametrised channel error injector for the encoder-to-decoder link of the convolutional/Viterbi chain. It carries W-bit code symbols through one register stage and flips selected bits according to a run-time mode: off, periodic burst, LFSR-random burst, or software one-shot. It also counts symbols, errored symbols and flipped bits over a bounded measurement window. It sits between the encoder output and the decoder input and is fully synthesizable, with no simulation-only randomness.

## Interface
- W, 2, symbol width; legal range 1..16
- PERIOD_LOG2, 5, periodic mode triggers every 2**PERIOD_LOG2 accepted symbols
- MAX_BURST, 8, largest burst length in symbols
- WINDOW, 256, symbols in the measurement window; 0 = unlimited
- SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'hACE1

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- mode_i  in  2  0 OFF, 1 PERIODIC, 2 RANDOM, 3 ONESHOT
- burst_len_i  in  $clog2(MAX_BURST+1)  burst length; 0 is treated as 1; values above MAX_BURST clamp to MAX_BURST
- rate_i  in  8  RANDOM trigger threshold; trigger when lfsr[7:0] < rate_i
- inj_i  in  1  ONESHOT trigger pulse
- valid_i  in  1  sym_i valid
- sym_i  in  W  clean symbol from encoder
- valid_o  out  1  sym_o valid
- sym_o  out  W  possibly corrupted symbol to decoder
- err_o  out  W  mask applied to sym_o (sym_o = sym_i ^ err_o)
- sym_ct_o  out  32  symbols accepted in window
- err_sym_ct_o  out  32  symbols with nonzero err_o
- err_bit_ct_o  out  32  total flipped bits
- window_done_o  out  1  window exhausted

## Operation
- An accepted symbol is one where valid_i=1. All state advances only on accepted symbols. When valid_i=0 nothing changes except valid_o.
- The 16-bit Galois LFSR uses x^16+x^14+x^13+x^11+1 and steps once per accepted symbol.
- The FSM has three states:
  - CLEAN: pass-through. A trigger loads burst_rem = burst_len-1, the current symbol is errored, and the FSM moves to BURST. If burst_len = 1, it stays in CLEAN.
  - BURST: the symbol is errored and burst_rem decrements. When burst_rem = 0, the FSM goes to CLEAN. Triggers are ignored (no reload). If mode_i becomes OFF, the burst aborts: the symbol is clean and the FSM returns to CLEAN.
  - DONE: entered when sym_ct reaches WINDOW (WINDOW ≠ 0). Pass-through only, counters frozen, window_done_o=1. DONE is left only by reset.
- Trigger per mode:
  - PERIODIC: sym_ct[PERIOD_LOG2-1:0] == all-ones.
  - RANDOM: lfsr[7:0] < rate_i. rate_i = 0 never triggers.
  - ONESHOT: the inj_i pulse is latched into a pending flag, and the trigger fires on the next accepted symbol, which clears the flag. Multiple pulses before that symbol yield a single burst.
- Mask of an errored symbol is lfsr[15:16-W]. If that value is zero, the mask becomes 1 (LSB), so every errored symbol flips at least one bit.
- Counters update on the cycle the symbol is output:
  - err_sym_ct increments by 1 per errored symbol.
  - err_bit_ct increments by popcount(err_o).
  - With WINDOW = 0, all counters saturate at 32'hFFFF_FFFF.

## Timing
- Latency is 1 cycle: sym_o, err_o and valid_o are registered from the cycle valid_i was sampled.
- Reset values:
  - valid_o=0, sym_o=0, err_o=0, all counters 0, window_done_o=0.
  - State CLEAN, LFSR=SEED, pending one-shot flag clear.
- Reset asserted mid-burst: the next cycle is clean, with the outputs above.
- mode_i, burst_len_i and rate_i are sampled on each accepted symbol. A mode change takes effect on that same symbol.
- inj_i and valid_i both high in the same cycle: the trigger applies to that symbol.
- Window boundary: the symbol that makes sym_ct = WINDOW is still processed and may be errored. window_done_o rises with that symbol's valid_o.
- Counters on the window-completing symbol: sym_ct_o reads WINDOW, and the other counters include that symbol.

## Structure
- Package chan_inj_pkg holds:
  - the mode enum (OFF/PERIODIC/RANDOM/ONESHOT)
  - the FSM state enum (CLEAN/BURST/DONE)
  - the LFSR tap constant 16'hB400 and the default seed
  - a popcount function
- One sub-module, lfsr16: enable and a seed parameter in, 16-bit state out.
- Target size is 150–250 lines of RTL.

## Test plan
- Reset, then mode OFF, then 300 symbols with valid_i=1 -> sym_o==sym_i delayed 1 cycle, err_o=0. sym_ct_o=256 with window_done_o=1 after symbol 256, and sym_ct_o stays 256.
- PERIODIC, PERIOD_LOG2=5, burst_len=2, 256 symbols -> errors on symbols 31,32, 63,64, … 255; err_sym_ct_o=15 (symbol 256 is never errored), every err_o nonzero.
- PERIODIC, burst_len=0 and then burst_len=15 (clamped to MAX_BURST=8) -> bursts of 1 and 8. Switching to OFF mid-burst -> the next symbol is clean.
- RANDOM with rate_i=0 -> no errors. With rate_i=255 -> ~255/256 symbols errored. err_bit_ct_o equals the summed popcount of the logged err_o.
- ONESHOT: two inj_i pulses during valid_i=0, then burst_len=3 -> exactly one 3-symbol burst. inj_i coincident with valid_i -> that symbol is errored.
- Drive valid_i with a 50% duty cycle -> the burst spans exactly burst_len valid symbols. Reset mid-burst -> outputs return to reset values and the LFSR restarts at SEED.
